// File: rtl/layer_00.sv
// rtl/layer_00.sv - first YOLO conv stage: banked feature-map store, 1x1 conv, bias, shift, ReLU, clamp
module layer_00 #(
  parameter int                 NUM_BANKS      = 16,
  parameter int                 ADDR_W         = 9,
  parameter int                 WORDS_PER_BANK = 128,
  parameter logic signed [7:0]  W0             = 8'sd1,
  parameter logic signed [7:0]  W1             = 8'sd2,
  parameter logic signed [7:0]  W2             = -8'sd1,
  parameter logic signed [7:0]  W3             = 8'sd4,
  parameter int                 SHIFT          = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  iStart,
  input  logic [NUM_BANKS-1:0]  i_ena,
  input  logic [ADDR_W-1:0]     i_addra,
  input  logic [NUM_BANKS-1:0]  i_wea,
  input  logic [127:0]          i_dia,
  input  logic signed [15:0]    iBias0,
  input  logic signed [15:0]    iBias1,
  input  logic signed [15:0]    iBias2,
  input  logic signed [15:0]    iBias3,
  output logic [7:0]            oLayer0_0,
  output logic [7:0]            oLayer0_1,
  output logic [7:0]            oLayer0_2,
  output logic [7:0]            oLayer0_3
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // rstn is active-high: 1 holds the block in reset
  logic                     rst;
  assign rst = rstn;

  logic [127:0]             mem [0:NUM_BANKS-1][0:DEPTH-1];

  state_t                   state;
  logic [BANK_W-1:0]        bank;
  logic [ADDR_W-1:0]        addr;
  logic signed [15:0]       bias0, bias1, bias2, bias3;

  // issue stage: the (bank, addr) presented to the read port
  logic                     iss_v;
  logic [BANK_W-1:0]        iss_bank;
  logic [ADDR_W-1:0]        iss_addr;

  // read-data stage
  logic                     data_v;
  logic [127:0]             rd_data;

  logic signed [11:0]       word_sum;
  logic [7:0]               act0, act1, act2, act3;

  // Sum of the 16 signed bytes; 12 bits covers -2048..2032 exactly
  function automatic logic signed [11:0] byte_sum(input logic [127:0] w);
    logic signed [11:0] s;
    s = '0;
    for (int k = 0; k < 16; k++) begin
      s = s + $signed({{4{w[8*k+7]}}, w[8*k +: 8]});
    end
    return s;
  endfunction

  // Weight, bias, arithmetic shift, then ReLU and clamp to 0..255
  function automatic logic [7:0] activate(input logic signed [11:0] s,
                                          input logic signed [7:0]  wt,
                                          input logic signed [15:0] b);
    logic signed [23:0] acc;
    logic signed [23:0] r;
    acc = $signed({{12{s[11]}}, s}) * $signed({{16{wt[7]}}, wt})
        + $signed({{8{b[15]}}, b});
    r = acc >>> SHIFT;
    if (r < 24'sd0) begin
      return 8'd0;
    end else if (r > 24'sd255) begin
      return 8'd255;
    end else begin
      return r[7:0];
    end
  endfunction

  // Load port: any enabled bank takes the write, in every state and through reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (i_ena[b] && i_wea[b]) begin
        mem[b][i_addra] <= i_dia;
      end
    end
  end

  // Registered read; a same-cycle write to the same word returns the old contents
  always_ff @(posedge clk) begin
    rd_data <= mem[iss_bank][iss_addr];
  end

  // Control FSM: bias latch on start, bank/addr walk, drain before re-arming
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bank  <= '0;
      addr  <= '0;
      bias0 <= '0;
      bias1 <= '0;
      bias2 <= '0;
      bias3 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            bias0 <= iBias0;
            bias1 <= iBias1;
            bias2 <= iBias2;
            bias3 <= iBias3;
            bank  <= '0;
            addr  <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (addr == ADDR_W'(WORDS_PER_BANK - 1)) begin
            addr <= '0;
            if (bank == BANK_W'(NUM_BANKS - 1)) begin
              state <= DONE;
            end else begin
              bank <= bank + 1'b1;
            end
          end else begin
            addr <= addr + 1'b1;
          end
        end
        DONE: begin
          // a held-high start must not retrigger; wait for drain and release
          if (!iss_v && !data_v && !iStart) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Issue stage: capture the word address of each RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_v    <= 1'b0;
      iss_bank <= '0;
      iss_addr <= '0;
    end else begin
      iss_v    <= (state == RUN);
      iss_bank <= bank;
      iss_addr <= addr;
    end
  end

  // Valid follows the read data by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      data_v <= 1'b0;
    end else begin
      data_v <= iss_v;
    end
  end

  assign word_sum = byte_sum(rd_data);
  assign act0     = activate(word_sum, W0, bias0);
  assign act1     = activate(word_sum, W1, bias1);
  assign act2     = activate(word_sum, W2, bias2);
  assign act3     = activate(word_sum, W3, bias3);

  // Output registers: update once per returned word, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      oLayer0_0 <= '0;
      oLayer0_1 <= '0;
      oLayer0_2 <= '0;
      oLayer0_3 <= '0;
    end else if (data_v) begin
      oLayer0_0 <= act0;
      oLayer0_1 <= act1;
      oLayer0_2 <= act2;
      oLayer0_3 <= act3;
    end
  end

endmodule

// File: tb/tb_layer_00.sv
// tb/tb_layer_00.sv - directed self-checking bench for layer_00
module tb_layer_00;

  logic               clk = 1'b0;
  logic               rstn;
  logic               iStart;
  logic [15:0]        i_ena;
  logic [8:0]         i_addra;
  logic [15:0]        i_wea;
  logic [127:0]       i_dia;
  logic signed [15:0] iBias0, iBias1, iBias2, iBias3;
  logic [7:0]         oLayer0_0, oLayer0_1, oLayer0_2, oLayer0_3;
  logic [31:0]        outs;

  int checks = 0;
  int errors = 0;

  layer_00 dut (
    .clk       (clk),
    .rstn      (rstn),
    .iStart    (iStart),
    .i_ena     (i_ena),
    .i_addra   (i_addra),
    .i_wea     (i_wea),
    .i_dia     (i_dia),
    .iBias0    (iBias0),
    .iBias1    (iBias1),
    .iBias2    (iBias2),
    .iBias3    (iBias3),
    .oLayer0_0 (oLayer0_0),
    .oLayer0_1 (oLayer0_1),
    .oLayer0_2 (oLayer0_2),
    .oLayer0_3 (oLayer0_3)
  );

  always #5 clk = ~clk;

  assign outs = {oLayer0_0, oLayer0_1, oLayer0_2, oLayer0_3};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int b, input int a, input logic [127:0] d);
    i_ena      = '0;
    i_wea      = '0;
    i_ena[b]   = 1'b1;
    i_wea[b]   = 1'b1;
    i_addra    = 9'(a);
    i_dia      = d;
    tick();
    i_ena      = '0;
    i_wea      = '0;
  endtask

  // Bank-specific pattern: bytes alternate v+b / v-b, so the byte sum is 16*v
  function automatic logic [127:0] pat_word(input int b, input int a);
    logic [127:0] w;
    int v;
    v = ((b * 128 + a) % 61) - 30;
    for (int k = 0; k < 16; k++) begin
      w[8*k +: 8] = 8'((k % 2 == 0) ? (v + b) : (v - b));
    end
    return w;
  endfunction

  function automatic logic [7:0] act(input int acc);
    int r;
    r = (acc >= 0) ? (acc / 4) : -((-acc + 3) / 4);
    if (r < 0) return 8'd0;
    if (r > 255) return 8'd255;
    return 8'(r);
  endfunction

  function automatic logic [31:0] model(input logic [127:0] w, input int b0, input int b1,
                                        input int b2, input int b3);
    byte sb;
    int  s;
    s = 0;
    for (int k = 0; k < 16; k++) begin
      sb = w[8*k +: 8];
      s += int'(sb);
    end
    return {act(s * 1 + b0), act(s * 2 + b1), act(-s + b2), act(s * 4 + b3)};
  endfunction

  initial begin
    rstn    = 1'b1;
    iStart  = 1'b0;
    i_ena   = '0;
    i_wea   = '0;
    i_addra = '0;
    i_dia   = '0;
    iBias0  = 16'sd0;
    iBias1  = 16'sd0;
    iBias2  = 16'sd0;
    iBias3  = 16'sd0;

    // reset state
    tick();
    tick();
    check("reset outputs", outs, 32'h0000_0000);
    rstn = 1'b0;
    repeat (5) tick();
    check("idle no change", outs, 32'h0000_0000);

    // single word: S=4, biases 8 -> 3/4/1/6
    wr(0, 0, 128'h0101_0101);
    iBias0 = 16'sd8; iBias1 = 16'sd8; iBias2 = 16'sd8; iBias3 = 16'sd8;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    tick();
    tick();
    check("single latency T+2", outs, 32'h0000_0000);
    tick();
    check("single word T+3", outs, 32'h0304_0106);
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    check("single abort", outs, 32'h0000_0000);

    // saturation: all bytes 0x7F, bias 0 -> 255/255/0/255
    wr(0, 0, {16{8'h7F}});
    iBias0 = 16'sd0; iBias1 = 16'sd0; iBias2 = 16'sd0; iBias3 = 16'sd0;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    repeat (3) tick();
    check("saturation", outs, 32'hFFFF_00FF);
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    repeat (3) tick();
    check("saturation abort hold", outs, 32'h0000_0000);

    // full sweep, iStart held high, bias0 changed mid-run
    for (int b = 0; b < 16; b++) begin
      for (int a = 0; a < 128; a++) begin
        wr(b, a, pat_word(b, a));
      end
    end
    iBias0 = 16'sd8; iBias1 = 16'sd8; iBias2 = 16'sd8; iBias3 = 16'sd8;
    iStart = 1'b1;
    tick();
    tick();
    tick();
    for (int n = 0; n < 2048; n++) begin
      tick();
      if (n == 0) check("sweep word0 hand", outs, 32'h0000_7A00);
      if (n == 2047) check("sweep last hand", outs, 32'h1222_0042);
      check($sformatf("sweep word %0d", n), outs, model(pat_word(n / 128, n % 128), 8, 8, 8, 8));
      if (n == 100) iBias0 = 16'sd100;
    end
    repeat (30) tick();
    check("held start no rerun", outs, 32'h1222_0042);
    iStart = 1'b0;
    repeat (5) tick();
    check("hold after done", outs, 32'h1222_0042);

    // second run uses the new bias0 = 100
    iStart = 1'b1;
    tick();
    tick();
    tick();
    for (int n = 0; n < 500; n++) begin
      tick();
      if (n == 60) check("run2 word60 hand", outs, 32'h91F2_00FF);
      check($sformatf("run2 word %0d", n), outs, model(pat_word(n / 128, n % 128), 100, 8, 8, 8));
    end

    // reset at word 500
    iStart = 1'b0;
    rstn   = 1'b1;
    tick();
    check("reset mid-run", outs, 32'h0000_0000);
    rstn = 1'b0;
    repeat (4) tick();
    check("no update after abort", outs, 32'h0000_0000);

    // fresh run restarts at bank0 addr0
    iBias0 = 16'sd8;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    tick();
    tick();
    check("restart latency", outs, 32'h0000_0000);
    tick();
    check("restart word0", outs, 32'h0000_7A00);
    tick();
    check("restart word1", outs, model(pat_word(0, 1), 8, 8, 8, 8));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
